data_memory_bytelane: RTL

//  Parametrised data memory for the pipelined MIPS core. It is byte-addressed, word-organised and supports
//  lb/lbu/lh/lhu/lw/sb/sh/sw. A post-reset clear sequence and a valid/ready request port feed a fixed-latency,
//  in-order response pipe. It sits in the MEM stage; the core stalls on req_ready=0.

---
 rtl/data_memory_bytelane.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/data_memory_bytelane.sv
// Byte-addressed, word-organised data memory for the MEM stage.
// Post-reset clear sequence, valid/ready request, fixed-latency in-order response pipe.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   req_valid/ready     request handshake (ready=0 while clearing)
//   req_wr              1=store, 0=load
//   req_size            0=byte, 1=half, 2=word, 3=illegal
//   req_unsigned        loads: 1=zero-extend, 0=sign-extend
//   req_addr/wdata      byte address, right-justified store data
//   rsp_valid           one pulse per accepted request, in order
//   rsp_rdata/rsp_err   extended load data / error flag (0 when idle)
module data_memory_bytelane #(
  parameter int DEPTH_WORDS = 64,
  parameter int RD_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = AW + 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_accept;
  logic [AW-1:0]   w_idx;
  logic            w_oor;
  logic            w_misal;
  logic            w_err;
  logic [4:0]      w_shift;
  logic [31:0]     w_word;
  logic [31:0]     w_wr_word;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_ld;
  logic [31:0]     w_rdata;

  logic            r_pv [RD_LATENCY];
  logic [31:0]     r_pd [RD_LATENCY];
  logic            r_pe [RD_LATENCY];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      // Counter stops in RUN, so it never wraps
      if (r_state == S_INIT)
        r_cnt <= r_cnt + CW'(1);
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (r_state == S_INIT &&
        r_cnt == CW'(DEPTH_WORDS - 1))
      w_next = S_RUN;
  end

  // FSM outputs
  always_comb begin
    req_ready = (r_state == S_RUN);
  end

  assign w_accept = req_valid & req_ready;
  assign w_idx    = req_addr[2 +: AW];
  assign w_oor    = req_addr >= 32'(4 * DEPTH_WORDS);
  assign w_misal  = (req_size == 2'd1 && req_addr[0]) ||
                    (req_size == 2'd2 && req_addr[1:0] != 2'd0);
  assign w_err    = w_oor | w_misal | (req_size == 2'd3);
  assign w_shift  = {req_addr[1:0], 3'b000};
  assign w_word   = r_mem[w_idx];
  assign w_byte   = w_word[w_shift +: 8];
  assign w_half   = req_addr[1] ? w_word[31:16] : w_word[15:0];

  // Merge store data into the current word; untouched lanes kept
  always_comb begin
    w_wr_word = w_word;
    case (req_size)
      2'd0: w_wr_word[w_shift +: 8] = req_wdata[7:0];
      2'd1: begin
        if (req_addr[1])
          w_wr_word[31:16] = req_wdata[15:0];
        else
          w_wr_word[15:0]  = req_wdata[15:0];
      end
      2'd2: w_wr_word = req_wdata;
      default: w_wr_word = w_word;
    endcase
  end

  always_comb begin
    w_ld = '0;
    case (req_size)
      2'd0: w_ld = {{24{~req_unsigned & w_byte[7]}}, w_byte};
      2'd1: w_ld = {{16{~req_unsigned & w_half[15]}}, w_half};
      2'd2: w_ld = w_word;
      default: w_ld = '0;
    endcase
  end

  assign w_rdata = (req_wr | w_err) ? 32'd0 : w_ld;

  // Clear sweep during INIT, committed stores during RUN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_INIT)
        r_mem[r_cnt[AW-1:0]] <= '0;
      else if (w_accept & req_wr & ~w_err)
        r_mem[w_idx] <= w_wr_word;
    end
  end

  // Response pipe: stage 0 captured at the accept edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= '0;
        r_pe[i] <= 1'b0;
      end
    end else begin
      r_pv[0] <= w_accept;
      r_pd[0] <= w_accept ? w_rdata : 32'd0;
      r_pe[0] <= w_accept & w_err;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pd[i] <= r_pd[i-1];
        r_pe[i] <= r_pe[i-1];
      end
    end
  end

  assign rsp_valid = r_pv[RD_LATENCY-1];
  assign rsp_rdata = r_pv[RD_LATENCY-1] ? r_pd[RD_LATENCY-1] : 32'd0;
  assign rsp_err   = r_pv[RD_LATENCY-1] & r_pe[RD_LATENCY-1];

endmodule
